logic_processor_param: RTL
==========================

// Module: logic_processor_param
// PURPOSE
// Parametrised bit-serial logic processor, successor to the fixed 8-bit Lab 4 unit.
// Holds two WIDTH-bit registers A and B, loads either from Din, and on execute
// applies one of 8 bitwise functions STEP bits per clock. Result is routed back to A/B per R.
// Adds: configurable width/step, F/R latched at start, busy/done flags, one op per execute press.
// PARAMETERS
// WIDTH  8  register width in bits; must be a multiple of STEP
// STEP   1  bits processed per clock; op takes WIDTH/STEP shift cycles
// PORTS
// clk      in   1          rising-edge clock
// reset    in   1          asynchronous, active-high; clears all state
// loadA    in   1          active-high; load Din into A (IDLE only)
// loadB    in   1          active-high; load Din into B (IDLE only)
// execute  in   1          active-high; start one operation (IDLE only)
// Din      in   WIDTH      load data
// F        in   3          function select
// R        in   2          routing select
// Aval     out  WIDTH      register A contents
// Bval     out  WIDTH      register B contents
// busy     out  1          high while in SHIFT
// done     out  1          one-cycle pulse on completion
// BEHAVIOUR
// - Reset (any time, incl. mid-op): A=B=0, state=IDLE, step count=0, busy=0, done=0,
//   latched F/R=0.
// - F: 000 AND, 001 OR, 010 XOR, 011 all-ones, 100 NAND, 101 NOR, 110 XNOR, 111 all-zeros.
// - R: 00 A<=A,B<=B; 01 A<=A,B<=f; 10 A<=f,B<=B; 11 A<=B,B<=A (swap).
//   A and B on the right-hand side are the pre-op values; f = F(A,B).
// - FSM: IDLE -> SHIFT -> HOLD -> IDLE.
// - IDLE:
//   - loadA/loadB load Din on the edge; both high loads both.
//   - execute=1 has priority over loads: go to SHIFT, latch F and R, step count=0.
//     Loads asserted on that edge are dropped.
// - SHIFT: N=WIDTH/STEP edges. Each edge:
//   - take the low STEP bits of A and B and compute f with the latched F;
//   - shift A and B right by STEP;
//   - insert the routed STEP-bit slices at the MSB end.
//   After N edges both registers hold full results with original bit order.
//   - Aval/Bval show the partially rotated contents mid-op; this is legal.
//   - F, R, loadA, loadB, execute are ignored during SHIFT.
//   - On the Nth edge go to HOLD and assert done for exactly one cycle.
// - HOLD: stay while execute=1; go to IDLE on the first edge with execute=0.
//   Loads are ignored. So one op per press.
// - busy = (state==SHIFT), registered. Step counter is sized $clog2(N)+1 and never wraps.
// - Latency: execute sampled at edge e0; result complete and done=1 after edge e0+N.
// TESTING
// 1. W=8,S=1: load A=0x33, B=0x55; F=010, R=10, pulse execute
//    -> after 8 shift edges A=0x66, B=0x55; done 1 cycle.
// 2. Then F=110, R=01, execute -> A=0x66, B=0xCC. Then R=11, execute -> A=0xCC, B=0x66.
// 3. Hold execute high 30 cycles -> exactly one op, one done pulse; FSM stays in HOLD
//    until execute=0.
// 4. Assert reset after 4th shift edge -> A=B=0, busy=0, IDLE immediately (async);
//    a new op then runs normally.
// 5. Mid-op change F/R and pulse loadA with Din=0xFF -> no effect; result matches test 1.
// 6. W=16,S=4: A=0x1234, B=0x00FF, F=000, R=10 -> done after 4 edges, A=0x0034, B=0x00FF.

Source files
------------

// File: rtl/logic_processor_param.sv
// Bit-serial logic processor: two WIDTH-bit registers A and B, loadable from
// Din while idle. One execute press runs one bitwise function over the pair,
// STEP bits per clock, and routes the result back into A/B.
//
// Control inputs (loadA, loadB, execute) are level-sampled on the rising edge.
// They only have an effect in IDLE, and execute wins over the loads. Each
// press produces exactly one operation: the unit parks in HOLD until execute
// drops. done pulses for one cycle on the edge that completes the result.
module logic_processor_param #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loadA,
    input  logic             loadB,
    input  logic             execute,
    input  logic [WIDTH-1:0] Din,
    input  logic [2:0]       F,
    input  logic [1:0]       R,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] a_q, b_q, a_n, b_n;
    logic [2:0]       f_q, f_n;
    logic [1:0]       r_q, r_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             done_n;
    logic             last_step;

    logic [STEP-1:0]  a_lo, b_lo, f_lo, a_ins, b_ins;

    assign a_lo      = a_q[STEP-1:0];
    assign b_lo      = b_q[STEP-1:0];
    assign last_step = (cnt_q == CW'(N - 1));

    // Function slice on the low STEP bits, using the F latched at start.
    always_comb begin
        f_lo = '0;
        case (f_q)
            3'b000:  f_lo = a_lo & b_lo;
            3'b001:  f_lo = a_lo | b_lo;
            3'b010:  f_lo = a_lo ^ b_lo;
            3'b011:  f_lo = '1;
            3'b100:  f_lo = ~(a_lo & b_lo);
            3'b101:  f_lo = ~(a_lo | b_lo);
            3'b110:  f_lo = ~(a_lo ^ b_lo);
            default: f_lo = '0;
        endcase
    end

    // Routing of the slices re-inserted at the MSB end. After N rotations the
    // inserted slices sit back at their original bit positions, so a swap
    // route simply feeds each register the other's low slice.
    always_comb begin
        a_ins = a_lo;
        b_ins = b_lo;
        case (r_q)
            2'b00: begin a_ins = a_lo; b_ins = b_lo; end
            2'b01: begin a_ins = a_lo; b_ins = f_lo; end
            2'b10: begin a_ins = f_lo; b_ins = b_lo; end
            default: begin a_ins = b_lo; b_ins = a_lo; end
        endcase
    end

    // Next-state, datapath and done-pulse decode.
    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        f_n     = f_q;
        r_n     = r_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (execute) begin
                    // Loads on the same edge are intentionally dropped.
                    state_n = SHIFT;
                    f_n     = F;
                    r_n     = R;
                    cnt_n   = '0;
                end else begin
                    if (loadA) a_n = Din;
                    if (loadB) b_n = Din;
                end
            end
            SHIFT: begin
                a_n = (a_q >> STEP) | (WIDTH'(a_ins) << (WIDTH - STEP));
                b_n = (b_q >> STEP) | (WIDTH'(b_ins) << (WIDTH - STEP));
                if (last_step) begin
                    state_n = HOLD;
                    done_n  = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (!execute) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            f_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            a_q   <= a_n;
            b_q   <= b_n;
            f_q   <= f_n;
            r_q   <= r_n;
            cnt_q <= cnt_n;
            busy  <= (state_n == SHIFT);
            done  <= done_n;
        end
    end

    assign Aval      = a_q;
    assign Bval      = b_q;
    assign state_dbg = state;

endmodule
